// File: rtl/corr_search_sequencer_if.sv
// corr_search_sequencer_if: single-cycle register bus between the sequencer and the correlator register map
interface corr_search_sequencer_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic        read;
    logic [31:0] rdata;
    modport master (output addr, wdata, write, read, input rdata);
    modport slave  (input addr, wdata, write, read, output rdata);
endinterface

// File: rtl/corr_search_sequencer.sv
// corr_search_sequencer: sweeps frequency bins on one correlator channel and reports the strongest bin
module corr_search_sequencer #(
    parameter logic [31:0] GLOBAL_BASE = 32'hFE00_0100,
    parameter logic [31:0] FREQ_BASE   = 32'hFE00_03D0,
    parameter logic [31:0] CHIP_BASE   = 32'hFE00_05D0,
    parameter logic [31:0] CORR_BASE   = 32'hFE00_07D0,
    parameter int unsigned TIMEOUT     = 1048576
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic                    i_abort,
    input  logic [31:0]             i_freq_start,
    input  logic [31:0]             i_freq_step,
    input  logic [7:0]              i_num_bins,
    input  logic [31:0]             i_chip_freq,
    input  logic [31:0]             i_prn_init,
    input  logic                    i_corr_seen,
    corr_search_sequencer_if.master bus,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [7:0]              o_best_bin,
    output logic [63:0]             o_best_mag,
    output logic                    o_timeout_err
);
    localparam logic [4:0] S_IDLE = 5'd0, S_STOP0 = 5'd1, S_CTL0 = 5'd2, S_FADD = 5'd3, S_FPH = 5'd4,
                           S_CFRQ = 5'd5, S_CPH = 5'd6, S_PRN = 5'd7, S_CTL1 = 5'd8, S_RUN = 5'd9,
                           S_WAIT = 5'd10, S_RDLO = 5'd11, S_RDHI = 5'd12, S_RDST = 5'd13, S_EVAL = 5'd14,
                           S_FIN = 5'd15, S_TOSTOP = 5'd16, S_AB0 = 5'd17, S_AB1 = 5'd18;
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    logic [4:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_freq, r_step, r_chip, r_prn, r_lo, r_hi;
    logic [7:0]    r_bin, r_last_bin, r_best_bin;
    logic [63:0]   r_best_mag;
    logic          r_to, r_have, r_done, r_terr;
    logic          w_wr, w_rd;
    logic [31:0]   w_addr, w_wdata;
    logic [63:0]   w_v, w_mag;

    assign w_v   = {r_hi, r_lo};
    assign w_mag = w_v[63] ? (~w_v + 64'd1) : w_v;

    // Bus access decoded purely from the state so an async reset drops strobes at once
    always_comb begin
        w_wr    = 1'b1;
        w_rd    = 1'b0;
        w_addr  = 32'h0;
        w_wdata = 32'h0;
        case (r_state)
            S_STOP0, S_TOSTOP, S_FIN, S_AB0: w_addr = GLOBAL_BASE;
            S_CTL0, S_AB1:                   w_addr = FREQ_BASE + 32'hC;
            S_FADD: begin w_addr = FREQ_BASE;          w_wdata = r_freq; end
            S_FPH:        w_addr = FREQ_BASE + 32'h4;
            S_CFRQ: begin w_addr = CHIP_BASE;          w_wdata = r_chip; end
            S_CPH:        w_addr = CHIP_BASE + 32'h4;
            S_PRN:  begin w_addr = CHIP_BASE + 32'hC;  w_wdata = r_prn; end
            S_CTL1: begin w_addr = FREQ_BASE + 32'hC;  w_wdata = 32'd1; end
            S_RUN:  begin w_addr = GLOBAL_BASE;        w_wdata = 32'd1; end
            S_RDLO: begin w_wr = 1'b0; w_rd = 1'b1; w_addr = CORR_BASE + 32'h4; end
            S_RDHI: begin w_wr = 1'b0; w_rd = 1'b1; w_addr = CORR_BASE + 32'h8; end
            S_RDST: begin w_wr = 1'b0; w_rd = 1'b1; w_addr = CORR_BASE + 32'hC; end
            default:      w_wr = 1'b0;
        endcase
    end

    assign bus.write     = w_wr;
    assign bus.read      = w_rd;
    assign bus.addr      = w_addr;
    assign bus.wdata     = w_wdata;
    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = r_done;
    assign o_best_bin    = r_best_bin;
    assign o_best_mag    = r_best_mag;
    assign o_timeout_err = r_terr;

    // Sweep state machine with per-bin timeout and best-magnitude tracking
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_freq     <= 32'h0;
            r_step     <= 32'h0;
            r_chip     <= 32'h0;
            r_prn      <= 32'h0;
            r_lo       <= 32'h0;
            r_hi       <= 32'h0;
            r_bin      <= 8'h0;
            r_last_bin <= 8'h0;
            r_best_bin <= 8'h0;
            r_best_mag <= 64'h0;
            r_to       <= 1'b0;
            r_have     <= 1'b0;
            r_done     <= 1'b0;
            r_terr     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_abort && r_state != S_IDLE && r_state != S_AB0 && r_state != S_AB1) begin
                r_state <= S_AB0;
            end else begin
                case (r_state)
                    S_IDLE: if (i_start) begin
                        r_freq     <= i_freq_start;
                        r_step     <= i_freq_step;
                        r_chip     <= i_chip_freq;
                        r_prn      <= i_prn_init;
                        r_last_bin <= (i_num_bins == 8'd0) ? 8'd0 : i_num_bins - 8'd1;
                        r_bin      <= 8'd0;
                        r_best_bin <= 8'd0;
                        r_best_mag <= 64'd0;
                        r_have     <= 1'b0;
                        r_terr     <= 1'b0;
                        r_state    <= S_STOP0;
                    end
                    S_STOP0: r_state <= S_CTL0;
                    S_CTL0:  r_state <= S_FADD;
                    S_FADD:  begin r_to <= 1'b0; r_state <= S_FPH; end
                    S_FPH:   r_state <= S_CFRQ;
                    S_CFRQ:  r_state <= S_CPH;
                    S_CPH:   r_state <= S_PRN;
                    S_PRN:   r_state <= S_CTL1;
                    S_CTL1:  r_state <= S_RUN;
                    S_RUN:   begin r_cnt <= '0; r_state <= S_WAIT; end
                    S_WAIT: begin
                        if (i_corr_seen) r_state <= S_RDLO;
                        else if (r_cnt == CNT_MAX) begin
                            r_terr  <= 1'b1;
                            r_to    <= 1'b1;
                            r_state <= S_TOSTOP;
                        end else r_cnt <= r_cnt + 1'b1;
                    end
                    S_RDLO:   begin r_lo <= bus.rdata; r_state <= S_RDHI; end
                    S_RDHI:   begin r_hi <= bus.rdata; r_state <= S_RDST; end
                    S_RDST:   r_state <= S_EVAL;
                    S_TOSTOP: r_state <= S_EVAL;
                    S_EVAL: begin
                        if (!r_to && (!r_have || w_mag > r_best_mag)) begin
                            r_best_bin <= r_bin;
                            r_best_mag <= w_mag;
                            r_have     <= 1'b1;
                        end
                        if (r_bin == r_last_bin) r_state <= S_FIN;
                        else begin
                            r_bin   <= r_bin + 8'd1;
                            r_freq  <= r_freq + r_step;
                            r_state <= S_FADD;
                        end
                    end
                    S_FIN:   begin r_done <= 1'b1; r_state <= S_IDLE; end
                    S_AB0:   r_state <= S_AB1;
                    S_AB1:   r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_corr_search_sequencer.sv
// tb_corr_search_sequencer: directed scenario checks of the frequency-bin search sequencer
`timescale 1ns/1ps
module tb_corr_search_sequencer;
    localparam logic [31:0] GB = 32'hFE00_0100, FB = 32'hFE00_03D0, CB = 32'hFE00_05D0, RB = 32'hFE00_07D0;
    localparam int TO = 32;

    logic        clk = 0, rst_n = 0, start = 0, abort = 0, corr_seen = 0;
    logic [31:0] freq_start = 0, freq_step = 0, chip_freq = 0, prn_init = 0;
    logic [7:0]  num_bins = 0;
    logic        busy, done, timeout_err;
    logic [7:0]  best_bin;
    logic [63:0] best_mag;
    logic [31:0] t_lo = 0, t_hi = 0;
    int          errors = 0, checks = 0, cyc = 0, viol = 0, done_cnt = 0, done_busy_bad = 0;
    logic        prev_busy = 0;
    logic [65:0] lg[$];
    int          lg_cyc[$];

    corr_search_sequencer_if bus ();

    corr_search_sequencer #(.TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_freq_start(freq_start), .i_freq_step(freq_step), .i_num_bins(num_bins),
        .i_chip_freq(chip_freq), .i_prn_init(prn_init), .i_corr_seen(corr_seen),
        .bus(bus), .o_busy(busy), .o_done(done), .o_best_bin(best_bin),
        .o_best_mag(best_mag), .o_timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.rdata = !bus.read ? 32'h0 :
                       (bus.addr == RB + 32'h4) ? t_lo :
                       (bus.addr == RB + 32'h8) ? t_hi :
                       (bus.addr == RB + 32'hC) ? {31'h0, corr_seen} : 32'h0;

    // Bus monitor: logs every access and flags bus-rule and done/busy violations
    always @(negedge clk) begin
        if (bus.write && bus.read) viol++;
        if (!bus.write && !bus.read && (bus.addr != 0 || bus.wdata != 0)) viol++;
        if (bus.write || bus.read) begin
            lg.push_back({bus.write, bus.read, bus.addr, bus.write ? bus.wdata : bus.rdata});
            lg_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            if (busy || !prev_busy) done_busy_bad++;
        end
        prev_busy = busy;
    end

    task automatic do_start(input logic [31:0] fs, st, input logic [7:0] nb, input logic [31:0] cf, pr);
        @(posedge clk); #1;
        freq_start = fs; freq_step = st; num_bins = nb; chip_freq = cf; prn_init = pr; start = 1;
        @(posedge clk); #1;
        start = 0; freq_start = 32'hDEAD_BEEF; freq_step = 32'h1234_5678; num_bins = 8'd7;
        chip_freq = 32'h0; prn_init = 32'h0;
    endtask

    task automatic wait_acc(input logic [65:0] pat, input int from, output int idx);
        int n = 0;
        idx = -1;
        while (idx < 0 && n < 3000) begin
            @(negedge clk); #1; n++;
            for (int i = from; i < lg.size(); i++) if (idx < 0 && lg[i] == pat) idx = i;
        end
        if (idx < 0) begin
            checks++; errors++;
            $display("FAIL wait_acc: access %h not seen, got none within %0d cycles", pat, n);
        end
    endtask

    task automatic serve(input int dly, input logic [63:0] v, input int from, output int nxt);
        int i0, i1;
        wait_acc({2'b10, GB, 32'h1}, from, i0);
        repeat (dly) @(posedge clk);
        #1; t_lo = v[31:0]; t_hi = v[63:32]; corr_seen = 1;
        wait_acc({2'b01, RB + 32'hC, 32'h1}, i0 + 1, i1);
        corr_seen = 0;
        nxt = i1 + 1;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin @(negedge clk); #1; n++; end while (busy && n < 3000);
        if (busy) begin
            checks++; errors++;
            $display("FAIL wait_idle: busy=%b still high after %0d cycles, want 0", busy, n);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, timeout_err, best_bin, best_mag, bus.write, bus.read, bus.addr, bus.wdata} !== '0)
            begin errors++; $display("FAIL reset_outputs: got busy=%b done=%b terr=%b bin=%h mag=%h wr=%b rd=%b addr=%h wd=%h, want all 0",
                busy, done, timeout_err, best_bin, best_mag, bus.write, bus.read, bus.addr, bus.wdata); end
        rst_n = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_sequence();
        int b, n, d0;
        logic [65:0] exp [13];
        exp = '{{2'b10, GB, 32'h0}, {2'b10, FB + 32'hC, 32'h0}, {2'b10, FB, 32'h1000}, {2'b10, FB + 32'h4, 32'h0},
                {2'b10, CB, 32'h4000_0000}, {2'b10, CB + 32'h4, 32'h0}, {2'b10, CB + 32'hC, 32'h2ABC_1235},
                {2'b10, FB + 32'hC, 32'h1}, {2'b10, GB, 32'h1}, {2'b01, RB + 32'h4, 32'h7},
                {2'b01, RB + 32'h8, 32'h0}, {2'b01, RB + 32'hC, 32'h1}, {2'b10, GB, 32'h0}};
        b = lg.size(); d0 = done_cnt;
        do_start(32'h1000, 32'h100, 8'd1, 32'h4000_0000, 32'h2ABC_1235);
        serve(20, 64'd7, b, n);
        wait_idle();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            checks++;
            if (lg[b + i] !== exp[i]) begin errors++; $display("FAIL seq_access[%0d]: got %h want %h", i, lg[b + i], exp[i]); end
        end
        checks++;
        if (lg.size() - b !== 13) begin errors++; $display("FAIL seq_count: got %0d accesses want 13", lg.size() - b); end
        checks++;
        if (done_cnt - d0 !== 1) begin errors++; $display("FAIL seq_done: got %0d pulses want 1", done_cnt - d0); end
        checks++;
        if (done_busy_bad !== 0) begin errors++; $display("FAIL seq_done_busy: got %0d bad pulses want 0", done_busy_bad); end
        checks++;
        if ({best_bin, best_mag} !== {8'd0, 64'd7}) begin errors++; $display("FAIL seq_best: got bin=%0d mag=%h want 0/7", best_bin, best_mag); end
    endtask

    task automatic test_magnitude();
        int b, n;
        logic [31:0] fw[$];
        b = lg.size();
        do_start(32'h1000, 32'h100, 8'd3, 32'h4000_0000, 32'h2ABC_1235);
        serve(4, 64'd5, b, n);
        serve(4, 64'hFFFF_FFFF_FFFF_FFF7, n, n);
        serve(4, 64'd9, n, n);
        wait_idle();
        checks++;
        if ({best_bin, best_mag} !== {8'd1, 64'd9}) begin errors++; $display("FAIL mag_best: got bin=%0d mag=%h want 1/9", best_bin, best_mag); end
        for (int i = b; i < lg.size(); i++) begin
            logic [65:0] e;
            e = lg[i];
            if (e[65:64] == 2'b10 && e[63:32] == FB) fw.push_back(e[31:0]);
        end
        checks++;
        if (fw.size() !== 3) begin errors++; $display("FAIL mag_dds_count: got %0d want 3", fw.size()); end
        else begin
            checks++;
            if ({fw[0], fw[1], fw[2]} !== {32'h1000, 32'h1100, 32'h1200})
                begin errors++; $display("FAIL mag_dds: got %h %h %h want 1000 1100 1200", fw[0], fw[1], fw[2]); end
        end
    endtask

    task automatic test_extremes();
        int b, n;
        b = lg.size();
        do_start(32'h2000, 32'h10, 8'd2, 32'h1, 32'h2);
        serve(3, 64'h8000_0000_0000_0000, b, n);
        serve(3, 64'h7FFF_FFFF_FFFF_FFFF, n, n);
        wait_idle();
        checks++;
        if ({best_bin, best_mag} !== {8'd0, 64'h8000_0000_0000_0000})
            begin errors++; $display("FAIL ext_best: got bin=%0d mag=%h want 0/8000000000000000", best_bin, best_mag); end
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL ext_terr: got %b want 0", timeout_err); end
    endtask

    task automatic test_timeout();
        int b, i0, i1, n, d0;
        b = lg.size(); d0 = done_cnt;
        do_start(32'h1000, 32'h100, 8'd2, 32'h5, 32'h6);
        wait_acc({2'b10, GB, 32'h1}, b, i0);
        wait_acc({2'b10, GB, 32'h0}, i0 + 1, i1);
        checks++;
        if (i1 !== i0 + 1) begin errors++; $display("FAIL to_no_reads: got stop at entry %0d want %0d", i1, i0 + 1); end
        checks++;
        if (lg_cyc[i1] - lg_cyc[i0] !== TO + 1) begin errors++; $display("FAIL to_cycles: got %0d want %0d", lg_cyc[i1] - lg_cyc[i0], TO + 1); end
        checks++;
        if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err_set: got %b want 1", timeout_err); end
        serve(3, 64'd3, i1 + 1, n);
        wait_idle();
        checks++;
        if (lg[i1 + 1] !== {2'b10, FB, 32'h1100}) begin errors++; $display("FAIL to_next_bin: got %h want FADD 1100", lg[i1 + 1]); end
        checks++;
        if ({best_bin, best_mag, timeout_err} !== {8'd1, 64'd3, 1'b1})
            begin errors++; $display("FAIL to_best: got bin=%0d mag=%h terr=%b want 1/3/1", best_bin, best_mag, timeout_err); end
        checks++;
        if (done_cnt - d0 !== 1) begin errors++; $display("FAIL to_done: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_abort();
        int b, i0, b2, n, d0;
        b = lg.size(); d0 = done_cnt;
        do_start(32'h1000, 32'h100, 8'd2, 32'h5, 32'h6);
        wait_acc({2'b10, GB, 32'h1}, b, i0);
        repeat (5) @(posedge clk);
        #1; abort = 1; b2 = lg.size();
        @(posedge clk); #1; abort = 0;
        repeat (4) @(negedge clk);
        checks++;
        if ({lg[b2], lg[b2 + 1]} !== {2'b10, GB, 32'h0, 2'b10, FB + 32'hC, 32'h0})
            begin errors++; $display("FAIL abort_writes: got %h %h want GR=0 then ctl=0", lg[b2], lg[b2 + 1]); end
        checks++;
        if (lg.size() - b2 !== 2) begin errors++; $display("FAIL abort_count: got %0d want 2", lg.size() - b2); end
        checks++;
        if ({busy, done_cnt - d0} !== {1'b0, 32'd0}) begin errors++; $display("FAIL abort_idle: got busy=%b done=%0d want 0/0", busy, done_cnt - d0); end
        b = lg.size();
        @(posedge clk); #1;
        freq_start = 32'h1000; freq_step = 32'h0; num_bins = 8'd1; start = 1; abort = 1;
        @(posedge clk); #1; start = 0; abort = 0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL abort_start_wins: got busy=%b want 1", busy); end
        serve(2, 64'd11, b, n);
        wait_idle();
        checks++;
        if ({done_cnt - d0, best_mag} !== {32'd1, 64'd11}) begin errors++; $display("FAIL abort_restart: got done=%0d mag=%h want 1/b", done_cnt - d0, best_mag); end
    endtask

    task automatic test_edges();
        int b, n, runs, i0;
        logic [31:0] fw[$];
        b = lg.size(); runs = 0;
        do_start(32'h1000, 32'h100, 8'd0, 32'h5, 32'h6);
        serve(2, 64'd1, b, n);
        wait_idle();
        for (int i = b; i < lg.size(); i++) if (lg[i] == {2'b10, GB, 32'h1}) runs++;
        checks++;
        if (runs !== 1) begin errors++; $display("FAIL zero_bins: got %0d bins want 1", runs); end
        b = lg.size();
        do_start(32'hFFFF_FF00, 32'h200, 8'd2, 32'h5, 32'h6);
        serve(2, 64'd1, b, n);
        serve(2, 64'd2, n, n);
        wait_idle();
        for (int i = b; i < lg.size(); i++) begin
            logic [65:0] e;
            e = lg[i];
            if (e[65:64] == 2'b10 && e[63:32] == FB) fw.push_back(e[31:0]);
        end
        checks++;
        if ({fw[0], fw[1]} !== {32'hFFFF_FF00, 32'h0000_0100}) begin errors++; $display("FAIL freq_wrap: got %h %h want ffffff00 00000100", fw[0], fw[1]); end
        b = lg.size();
        do_start(32'h3000, 32'h100, 8'd1, 32'h5, 32'h6);
        wait_acc({2'b10, FB, 32'h3000}, b, i0);
        rst_n = 0;
        #1;
        checks++;
        if ({bus.write, bus.read, bus.addr, busy} !== '0)
            begin errors++; $display("FAIL reset_mid: got wr=%b rd=%b addr=%h busy=%b want all 0", bus.write, bus.read, bus.addr, busy); end
        @(negedge clk); rst_n = 1;
        b = lg.size();
        repeat (5) @(negedge clk);
        checks++;
        if ({lg.size() - b, busy} !== {32'd0, 1'b0}) begin errors++; $display("FAIL reset_quiet: got %0d accesses busy=%b want 0/0", lg.size() - b, busy); end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_magnitude();
        test_extremes();
        test_timeout();
        test_abort();
        test_edges();
        checks++;
        if (viol !== 0) begin errors++; $display("FAIL bus_rules: got %0d violations want 0", viol); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
